// File: rtl/write_arbiter.sv
// ============================================================================
// Module   : write_arbiter
// Brief    : Two-port AXI3 AW/W arbiter. Round-robin AW grant into a
//            registered output slot; W steered strictly in AW grant order.
//            Optional burst-length checking: WRITE_ARB_LEN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module write_arbiter #(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int USER_W    = 2,
  parameter int ORD_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  // port 0 (regular flow)
  input  logic                         s0_awvalid,
  output logic                         s0_awready,
  input  logic [ID_W-1:0]              s0_awid,
  input  logic [ADDR_W-1:0]            s0_awaddr,
  input  logic [3:0]                   s0_awlen,
  input  logic [2:0]                   s0_awsize,
  input  logic [1:0]                   s0_awburst,
  input  logic [USER_W-1:0]            s0_awuser,
  input  logic                         s0_wvalid,
  output logic                         s0_wready,
  input  logic [ID_W-1:0]              s0_wid,
  input  logic [DATA_W-1:0]            s0_wdata,
  input  logic [DATA_W/8-1:0]          s0_wstrb,
  input  logic                         s0_wlast,
  // port 1 (special-memory merge/replay)
  input  logic                         s1_awvalid,
  output logic                         s1_awready,
  input  logic [ID_W-1:0]              s1_awid,
  input  logic [ADDR_W-1:0]            s1_awaddr,
  input  logic [3:0]                   s1_awlen,
  input  logic [2:0]                   s1_awsize,
  input  logic [1:0]                   s1_awburst,
  input  logic [USER_W-1:0]            s1_awuser,
  input  logic                         s1_wvalid,
  output logic                         s1_wready,
  input  logic [ID_W-1:0]              s1_wid,
  input  logic [DATA_W-1:0]            s1_wdata,
  input  logic [DATA_W/8-1:0]          s1_wstrb,
  input  logic                         s1_wlast,
  // downstream master
  output logic                         m_awvalid,
  input  logic                         m_awready,
  output logic [ID_W-1:0]              m_awid,
  output logic [ADDR_W-1:0]            m_awaddr,
  output logic [3:0]                   m_awlen,
  output logic [2:0]                   m_awsize,
  output logic [1:0]                   m_awburst,
  output logic [USER_W-1:0]            m_awuser,
  output logic                         m_wvalid,
  input  logic                         m_wready,
  output logic [ID_W-1:0]              m_wid,
  output logic [DATA_W-1:0]            m_wdata,
  output logic [DATA_W/8-1:0]          m_wstrb,
  output logic                         m_wlast,
  output logic [$clog2(ORD_DEPTH):0]   ord_count,
  output logic                         len_err
);

  localparam int PTR_W = $clog2(ORD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] ORD_FULL = CNT_W'(ORD_DEPTH);

  localparam logic [0:0] AW_IDLE = 1'b0;
  localparam logic [0:0] AW_HOLD = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              rr_q, rr_d;
  logic [ID_W-1:0]   awid_q, awid_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [3:0]        awlen_q, awlen_d;
  logic [2:0]        awsize_q, awsize_d;
  logic [1:0]        awburst_q, awburst_d;
  logic [USER_W-1:0] awuser_q, awuser_d;
  logic [CNT_W-1:0]  ord_count_q, ord_count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              port_mem_q [ORD_DEPTH];
  logic              port_mem_d [ORD_DEPTH];

  logic w_empty, w_head, w_hs, w_pop, w_room, w_can_cap, w_push, w_winner;
  logic [3:0] w_push_len;

  // ---------------- W steering (combinational) ----------------
  assign w_empty   = (ord_count_q == '0);
  assign w_head    = port_mem_q[rd_ptr_q];
  assign m_wvalid  = !w_empty && (w_head ? s1_wvalid : s0_wvalid);
  assign s0_wready = !w_empty && !w_head && m_wready;
  assign s1_wready = !w_empty &&  w_head && m_wready;
  assign m_wid     = w_head ? s1_wid   : s0_wid;
  assign m_wdata   = w_head ? s1_wdata : s0_wdata;
  assign m_wstrb   = w_head ? s1_wstrb : s0_wstrb;
  assign m_wlast   = w_head ? s1_wlast : s0_wlast;
  assign w_hs      = m_wvalid && m_wready;
  assign w_pop     = w_hs && m_wlast;

  // A wlast pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign w_room    = (ord_count_q != ORD_FULL) || w_pop;
  assign w_can_cap = ((state_q == AW_IDLE) || m_awready) && w_room;
  assign w_winner  = (s0_awvalid && s1_awvalid) ? rr_q : s1_awvalid;
  assign w_push    = w_can_cap && (s0_awvalid || s1_awvalid);
  assign s0_awready = w_push && !w_winner;
  assign s1_awready = w_push &&  w_winner;
  assign w_push_len = w_winner ? s1_awlen : s0_awlen;

  // ---------------- AW FSM ----------------
  always_ff @(posedge clk) begin
    if (rst_n) state_q <= AW_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (w_push)         state_d = AW_HOLD;
    else if (m_awready) state_d = AW_IDLE;
  end

  always_comb begin
    m_awvalid = (state_q == AW_HOLD);
  end

  // ---------------- AW register, arbiter and order FIFO ----------------
  always_comb begin
    rr_d        = rr_q;
    awid_d      = awid_q;
    awaddr_d    = awaddr_q;
    awlen_d     = awlen_q;
    awsize_d    = awsize_q;
    awburst_d   = awburst_q;
    awuser_d    = awuser_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    port_mem_d  = port_mem_q;
    ord_count_d = ord_count_q;
    if (w_push) begin
      rr_d      = !w_winner;
      awid_d    = w_winner ? s1_awid    : s0_awid;
      awaddr_d  = w_winner ? s1_awaddr  : s0_awaddr;
      awlen_d   = w_push_len;
      awsize_d  = w_winner ? s1_awsize  : s0_awsize;
      awburst_d = w_winner ? s1_awburst : s0_awburst;
      awuser_d  = w_winner ? s1_awuser  : s0_awuser;
      port_mem_d[wr_ptr_q] = w_winner;
      wr_ptr_d  = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (w_push && !w_pop)      ord_count_d = ord_count_q + CNT_W'(1);
    else if (!w_push && w_pop) ord_count_d = ord_count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      rr_q        <= 1'b0;
      awid_q      <= '0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      awsize_q    <= '0;
      awburst_q   <= '0;
      awuser_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ord_count_q <= '0;
      for (int i = 0; i < ORD_DEPTH; i++) port_mem_q[i] <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      awid_q      <= awid_d;
      awaddr_q    <= awaddr_d;
      awlen_q     <= awlen_d;
      awsize_q    <= awsize_d;
      awburst_q   <= awburst_d;
      awuser_q    <= awuser_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ord_count_q <= ord_count_d;
      port_mem_q  <= port_mem_d;
    end
  end

  assign m_awid    = awid_q;
  assign m_awaddr  = awaddr_q;
  assign m_awlen   = awlen_q;
  assign m_awsize  = awsize_q;
  assign m_awburst = awburst_q;
  assign m_awuser  = awuser_q;
  assign ord_count = ord_count_q;

`ifdef WRITE_ARB_LEN_CHECK_EN
  logic [3:0] len_mem_q [ORD_DEPTH];
  logic [3:0] len_mem_d [ORD_DEPTH];
  logic [3:0] beat_q, beat_d;
  logic       len_err_q, len_err_d;

  // Beat counter tracks the head burst; it restarts whenever that burst pops.
  always_comb begin
    len_mem_d = len_mem_q;
    beat_d    = beat_q;
    len_err_d = len_err_q;
    if (w_push) len_mem_d[wr_ptr_q] = w_push_len;
    if (w_hs) begin
      if (m_wlast != (beat_q == len_mem_q[rd_ptr_q])) len_err_d = 1'b1;
      beat_d = w_pop ? 4'd0 : beat_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      beat_q    <= '0;
      len_err_q <= 1'b0;
      for (int i = 0; i < ORD_DEPTH; i++) len_mem_q[i] <= '0;
    end else begin
      beat_q    <= beat_d;
      len_err_q <= len_err_d;
      len_mem_q <= len_mem_d;
    end
  end

  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_write_arbiter.sv
// ============================================================================
// Module   : tb_write_arbiter
// Brief    : Directed self-checking bench for write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_write_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic s0_awvalid, s0_awready, s1_awvalid, s1_awready;
  logic [3:0]  s0_awid, s1_awid, s0_awlen, s1_awlen;
  logic [31:0] s0_awaddr, s1_awaddr;
  logic [2:0]  s0_awsize, s1_awsize;
  logic [1:0]  s0_awburst, s1_awburst, s0_awuser, s1_awuser;
  logic s0_wvalid, s0_wready, s1_wvalid, s1_wready;
  logic [3:0]  s0_wid, s1_wid;
  logic [31:0] s0_wdata, s1_wdata;
  logic [3:0]  s0_wstrb, s1_wstrb;
  logic s0_wlast, s1_wlast;
  logic m_awvalid, m_awready;
  logic [3:0]  m_awid, m_awlen;
  logic [31:0] m_awaddr;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst, m_awuser;
  logic m_wvalid, m_wready;
  logic [3:0]  m_wid;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic m_wlast;
  logic [2:0]  ord_count;
  logic len_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  write_arbiter #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .USER_W(2), .ORD_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_awid(s0_awid), .s0_awaddr(s0_awaddr),
    .s0_awlen(s0_awlen), .s0_awsize(s0_awsize), .s0_awburst(s0_awburst), .s0_awuser(s0_awuser),
    .s0_wvalid(s0_wvalid), .s0_wready(s0_wready), .s0_wid(s0_wid), .s0_wdata(s0_wdata),
    .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast),
    .s1_awvalid(s1_awvalid), .s1_awready(s1_awready), .s1_awid(s1_awid), .s1_awaddr(s1_awaddr),
    .s1_awlen(s1_awlen), .s1_awsize(s1_awsize), .s1_awburst(s1_awburst), .s1_awuser(s1_awuser),
    .s1_wvalid(s1_wvalid), .s1_wready(s1_wready), .s1_wid(s1_wid), .s1_wdata(s1_wdata),
    .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awuser(m_awuser),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wid(m_wid), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .ord_count(ord_count), .len_err(len_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    {s0_awvalid, s1_awvalid, s0_wvalid, s1_wvalid} = '0;
    {s0_awid, s1_awid, s0_awaddr, s1_awaddr, s0_awlen, s1_awlen} = '0;
    {s0_awsize, s1_awsize, s0_awburst, s1_awburst, s0_awuser, s1_awuser} = '0;
    {s0_wid, s1_wid, s0_wdata, s1_wdata, s0_wlast, s1_wlast} = '0;
    s0_wstrb = 4'hF; s1_wstrb = 4'hF;
    m_awready = 1'b0; m_wready = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
  endtask

  typedef struct {
    logic s0v, s1v;
    logic e_r0, e_r1, e_mval;
    logic [3:0] e_mid;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[4];
  logic exp_len_err;
  int gq[$];
  int wq[$];
  int g0, g1, w0, w1;
  int exp_order[6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef WRITE_ARB_LEN_CHECK_EN
    exp_len_err = 1'b1;
`else
    exp_len_err = 1'b0;
`endif
    vecs[0] = '{s0v:0, s1v:0, e_r0:0, e_r1:0, e_mval:0, e_mid:4'h0, e_wdata:32'h0};
    vecs[1] = '{s0v:1, s1v:0, e_r0:1, e_r1:0, e_mval:1, e_mid:4'h3, e_wdata:32'hAAAA0000};
    vecs[2] = '{s0v:0, s1v:1, e_r0:0, e_r1:1, e_mval:1, e_mid:4'h5, e_wdata:32'hBBBB1111};
    vecs[3] = '{s0v:1, s1v:1, e_r0:1, e_r1:0, e_mval:1, e_mid:4'h3, e_wdata:32'hAAAA0000};

    // reset state
    do_reset();
    chk("rst_m_awvalid", m_awvalid, 0);
    chk("rst_m_awaddr", m_awaddr, 0);
    chk("rst_ord_count", ord_count, 0);
    chk("rst_m_wvalid", m_wvalid, 0);
    chk("rst_len_err", len_err, 0);

    // table: single-cycle arbitration from reset, then W steering of the winner
    for (int i = 0; i < 4; i++) begin
      do_reset();
      m_wready = 1'b1;
      s0_awid = 4'h3; s1_awid = 4'h5;
      s0_awvalid = vecs[i].s0v; s1_awvalid = vecs[i].s1v;
      #1;
      chk($sformatf("v%0d_s0_awready", i), s0_awready, vecs[i].e_r0);
      chk($sformatf("v%0d_s1_awready", i), s1_awready, vecs[i].e_r1);
      tick();
      s0_awvalid = 1'b0; s1_awvalid = 1'b0;
      s0_wdata = 32'hAAAA0000; s1_wdata = 32'hBBBB1111;
      s0_wlast = 1'b1; s1_wlast = 1'b1;
      s0_wvalid = 1'b1; s1_wvalid = 1'b1;
      #1;
      chk($sformatf("v%0d_m_awvalid", i), m_awvalid, vecs[i].e_mval);
      chk($sformatf("v%0d_m_awid", i), m_awid, vecs[i].e_mid);
      chk($sformatf("v%0d_m_wvalid", i), m_wvalid, vecs[i].e_mval);
      if (vecs[i].e_mval) chk($sformatf("v%0d_m_wdata", i), m_wdata, vecs[i].e_wdata);
    end

    // single 4-beat burst on port 0
    do_reset();
    m_awready = 1'b1; m_wready = 1'b1;
    s0_awvalid = 1'b1; s0_awaddr = 32'h100; s0_awlen = 4'd3;
    #1 chk("sb_s0_awready", s0_awready, 1);
    tick();
    s0_awvalid = 1'b0;
    chk("sb_m_awvalid", m_awvalid, 1);
    chk("sb_m_awaddr", m_awaddr, 32'h100);
    chk("sb_m_awlen", m_awlen, 3);
    chk("sb_ord_count1", ord_count, 1);
    for (int b = 0; b < 4; b++) begin
      s0_wvalid = 1'b1; s0_wdata = 32'hD000 + b; s0_wlast = (b == 3);
      #1;
      chk($sformatf("sb_wdata%0d", b), m_wdata, 32'hD000 + b);
      chk($sformatf("sb_wlast%0d", b), m_wlast, (b == 3));
      tick();
    end
    s0_wvalid = 1'b0;
    chk("sb_ord_count0", ord_count, 0);

    // both ports x3, port 1 W presented first; grant and W order must match
    do_reset();
    m_awready = 1'b1; m_wready = 1'b1;
    s0_wlast = 1'b1; s1_wlast = 1'b1;
    s0_awid = 4'h0; s1_awid = 4'h1;
    g0 = 0; g1 = 0; w0 = 0; w1 = 0;
    gq.delete(); wq.delete();
    for (int cyc = 0; cyc < 60 && wq.size() < 6; cyc++) begin
      s0_awvalid = (g0 < 3); s1_awvalid = (g1 < 3);
      s1_wvalid = (w1 < 3); s1_wdata = 32'h1000_0000 | w1;
      s0_wvalid = (w0 < 3) && (cyc >= 8); s0_wdata = w0;
      #1;
      if (cyc == 5) begin
        chk("ord_full_count", ord_count, 4);
        chk("ord_full_awready", s0_awready | s1_awready, 0);
        chk("early_w_held_m_wvalid", m_wvalid, 0);
        chk("early_w_held_s1_wready", s1_wready, 0);
      end
      if (cyc == 8) chk("pop_same_cycle_capture", s0_awready, 1);
      if (s0_awvalid && s0_awready) begin gq.push_back(0); g0++; end
      if (s1_awvalid && s1_awready) begin gq.push_back(1); g1++; end
      if (m_wvalid && m_wready) begin
        wq.push_back(int'(m_wdata[28]));
        if (s0_wready) w0++;
        else w1++;
      end
      tick();
    end
    s0_awvalid = 1'b0; s1_awvalid = 1'b0; s0_wvalid = 1'b0; s1_wvalid = 1'b0;
    chk("order_grant_count", gq.size(), 6);
    chk("order_w_count", wq.size(), 6);
    for (int i = 0; i < gq.size() && i < 6; i++) chk($sformatf("grant_order%0d", i), gq[i], exp_order[i]);
    for (int i = 0; i < wq.size() && i < 6; i++) chk($sformatf("w_order%0d", i), wq[i], exp_order[i]);

    // AW stall: payload frozen, reload on drain, then fill to ORD_DEPTH
    do_reset();
    s0_awvalid = 1'b1; s0_awaddr = 32'hA0;
    s1_awvalid = 1'b1; s1_awaddr = 32'hB0;
    tick();
    s0_awvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stall_awvalid%0d", i), m_awvalid, 1);
      chk($sformatf("stall_awaddr%0d", i), m_awaddr, 32'hA0);
      chk($sformatf("stall_s1_awready%0d", i), s1_awready, 0);
      tick();
    end
    m_awready = 1'b1;
    #1 chk("reload_s1_awready", s1_awready, 1);
    tick();
    chk("reload_awvalid", m_awvalid, 1);
    chk("reload_awaddr", m_awaddr, 32'hB0);
    chk("reload_ord_count", ord_count, 2);
    s0_awvalid = 1'b1;
    tick(); tick();
    chk("fill_ord_count", ord_count, 4);
    chk("fill_s0_awready", s0_awready, 0);
    chk("fill_s1_awready", s1_awready, 0);

    // back-to-back single-beat bursts alternating ports
    do_reset();
    m_awready = 1'b1; m_wready = 1'b1;
    s0_awvalid = 1'b1; s1_awvalid = 1'b1;
    s0_wvalid = 1'b1; s1_wvalid = 1'b1;
    s0_wlast = 1'b1; s1_wlast = 1'b1;
    s0_wdata = 32'h0; s1_wdata = 32'h1;
    tick();
    for (int cyc = 1; cyc <= 8; cyc++) begin
      chk($sformatf("b2b_ord_count%0d", cyc), ord_count, 1);
      chk($sformatf("b2b_m_wvalid%0d", cyc), m_wvalid, 1);
      chk($sformatf("b2b_port%0d", cyc), m_wdata, (cyc - 1) % 2);
      tick();
    end

    // length check: awlen=1 burst terminated on beat 0
    do_reset();
    m_awready = 1'b1; m_wready = 1'b1;
    s0_awvalid = 1'b1; s0_awlen = 4'd1;
    tick();
    s0_awvalid = 1'b0;
    s0_wvalid = 1'b1; s0_wlast = 1'b1;
    #1 chk("len_err_before", len_err, 0);
    tick();
    s0_wvalid = 1'b0;
    chk("len_err_set", len_err, exp_len_err);
    tick(); tick(); tick();
    chk("len_err_sticky", len_err, exp_len_err);

    // reset during beat 2 of an awlen=7 burst, then a fresh burst
    do_reset();
    m_awready = 1'b1; m_wready = 1'b1;
    s0_awvalid = 1'b1; s0_awlen = 4'd7;
    tick();
    s0_awvalid = 1'b0;
    s0_wvalid = 1'b1; s0_wlast = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_m_wvalid", m_wvalid, 0);
    chk("mid_rst_s0_wready", s0_wready, 0);
    chk("mid_rst_m_awvalid", m_awvalid, 0);
    chk("mid_rst_ord_count", ord_count, 0);
    rst_n = 1'b0;
    s0_wvalid = 1'b0;
    s1_awvalid = 1'b1; s1_awlen = 4'd0;
    tick();
    s1_awvalid = 1'b0;
    chk("fresh_ord_count1", ord_count, 1);
    s1_wvalid = 1'b1; s1_wlast = 1'b1; s1_wdata = 32'hCAFE;
    #1;
    chk("fresh_m_wvalid", m_wvalid, 1);
    chk("fresh_m_wdata", m_wdata, 32'hCAFE);
    tick();
    s1_wvalid = 1'b0;
    chk("fresh_ord_count0", ord_count, 0);
    chk("fresh_len_err", len_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/write_arbiter.md
# write_arbiter

Two-port AXI3 write-channel arbiter that shares the single downstream AW/W master channel of the write-ordering unit between the regular-flow path (port 0) and the special-memory merge/replay path (port 1). It arbitrates AW requests round-robin, registers the winning address beat, and records the grant order in an order FIFO. The W channel is then steered strictly in AW grant order, one full burst at a time. It replaces the static state-based mux in the write-ordering top level.

## Interface
- ID_W, 4: awid/wid width
- ADDR_W, 32: awaddr width
- DATA_W, 32: wdata width (wstrb = DATA_W/8)
- USER_W, 2: awuser width
- ORD_DEPTH, 4: order-FIFO entries, power of two, ≥2
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous and active-high (asserted = 1)
- sN_awvalid / sN_awready (N=0,1)  in/out  1  AW handshake per port
- sN_awid, sN_awaddr, sN_awlen, sN_awsize, sN_awburst, sN_awuser  in  ID_W/ADDR_W/4/3/2/USER_W  AW payload
- sN_wvalid / sN_wready  in/out  1  W handshake per port
- sN_wid, sN_wdata, sN_wstrb, sN_wlast  in  ID_W/DATA_W/DATA_W/8/1  W payload
- m_awvalid / m_awready  out/in  1  downstream AW handshake
- m_awid … m_awuser  out  same widths  registered AW payload
- m_wvalid / m_wready  out/in  1  downstream W handshake
- m_wid, m_wdata, m_wstrb, m_wlast  out  same widths  W payload (muxed)
- ord_count  out  clog2(ORD_DEPTH)+1  bursts granted but not yet completed on W
- len_err  out  1  sticky burst-length violation (see Configuration)

## Operation
- AW FSM, states AW_IDLE (output register empty), AW_HOLD (m_awvalid=1, payload frozen).
- Capture condition: output register empty or draining this cycle (m_awvalid&m_awready), and ord_count < ORD_DEPTH.
- Arbiter: the port whose awvalid is set wins. When both are set, the port not granted last wins. rr pointer resets so that port 0 wins the first tie.
- On capture: assert the winner's sN_awready, load the payload into the output register, push the port index (plus awlen) into the order FIFO, toggle rr, go to AW_HOLD.
- AW_HOLD→AW_IDLE on m_awready with no new capture. It stays in AW_HOLD if it reloads in the same cycle.
- W steering: the head of the order FIFO selects the source port.
  - m_wvalid = FIFO non-empty & s[head]_wvalid.
  - s[head]_wready = FIFO non-empty & m_wready. The other port's wready = 0.
  - m_w* payload = s[head]_w*.
- Pop the order FIFO on m_wvalid&m_wready&m_wlast. The next burst's head is visible the following cycle.
- Simultaneous push and pop: ord_count unchanged. Push when full: never happens, because capture is blocked.
- W data arriving before its AW is granted is held off (wready=0) until its burst reaches the head.
- Payloads are never modified. wid is forwarded as received.

## Timing
- Reset values: m_awvalid=0, all sN_awready=0, sN_wready=0, m_wvalid=0, m_aw* payload=0, ord_count=0, len_err=0, rr→port 0, beat counter=0.
- sN_awready is combinational in the capture cycle, from sN_awvalid, register state and FIFO count.
- m_awvalid rises the cycle after capture. Sustained AW throughput is 1 beat/cycle when m_awready=1.
- W path is combinational, 0 cycles from s to m. Throughput is 1 beat/cycle, and 1 idle cycle at most between bursts of different ports.
- m_awvalid, once high, holds with a stable payload until m_awready.
- Reset asserted mid-burst: next cycle all state is cleared and all valids/readys drop. Upstream re-issues.

## Configuration
- WRITE_ARB_LEN_CHECK_EN defined:
  - the FIFO also stores awlen, and a beat counter counts W handshakes of the head burst;
  - len_err is set (sticky until reset) when m_wlast differs from (beat == awlen) on any handshake;
  - data is still forwarded unchanged.
- Undefined: no awlen storage and no counter; len_err tied 0.

## Test plan
- Single burst on port 0: awlen=3, addr 0x100, m_awready=1 → m_awvalid one cycle after s0_awready, 4 W beats forwarded, ord_count 1→0 after wlast.
- Both ports assert awvalid from reset, three times each → grant order 0,1,0,1,0,1. W bursts complete in that order even when port 1's W data is presented first.
- m_awready=0 for 10 cycles with both ports requesting:
  - payload stable during the stall;
  - captures stop once ord_count=ORD_DEPTH=4;
  - the next capture happens in the same cycle as a wlast pop.
- Back-to-back single-beat bursts alternating ports with m_wready=1 → no more than one idle W cycle between bursts. A simultaneous push and pop keeps ord_count constant.
- WRITE_ARB_LEN_CHECK_EN: awlen=1 burst with wlast on beat 0 → len_err=1 and stays 1. Without the macro → len_err=0.
- Assert rst_n=1 during beat 2 of an awlen=7 burst → next cycle all valids/readys are 0 and ord_count=0. A fresh burst after reset completes normally.
